// File: rtl/ex_hilo_unit_pkg.sv
// ex_hilo_unit_pkg: shared definitions for the HI/LO arithmetic unit.
//   - HI/LO operation codes carried on the 4-bit op bus
//   - divider FSM state encoding
//   - conditional two's-complement helper used for sign handling
package ex_hilo_unit_pkg;

  localparam int RegW     = 32;
  localparam int HiLoOpW  = 4;

  localparam logic [HiLoOpW-1:0] HiLoNop   = 4'd0;
  localparam logic [HiLoOpW-1:0] HiLoMult  = 4'd1;
  localparam logic [HiLoOpW-1:0] HiLoMultu = 4'd2;
  localparam logic [HiLoOpW-1:0] HiLoMadd  = 4'd3;
  localparam logic [HiLoOpW-1:0] HiLoMaddu = 4'd4;
  localparam logic [HiLoOpW-1:0] HiLoMsub  = 4'd5;
  localparam logic [HiLoOpW-1:0] HiLoMsubu = 4'd6;
  localparam logic [HiLoOpW-1:0] HiLoDiv   = 4'd7;
  localparam logic [HiLoOpW-1:0] HiLoDivu  = 4'd8;

  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_e;

  // Two's-complement negate when neg is set, pass through otherwise.
  function automatic logic [RegW-1:0] cond_neg(input logic [RegW-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_hilo_unit_div.sv
// hilo_div: 32-cycle restoring divider for DIV/DIVU.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         a DIV/DIVU op is present in EX
//   annul_i         flush: return to DivFree on the next edge
//   signed_i        DIV (1) or DIVU (0)
//   dividend_i      dividend (rs)
//   divisor_i       divisor (rt)
//   busy_o          division in progress, stall required this cycle
//   ready_o         result valid this cycle (DivEnd)
//   quo_o, rem_o    signed-corrected quotient and remainder (valid with ready_o)
module hilo_div
  import ex_hilo_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            annul_i,
  input  logic            signed_i,
  input  logic [RegW-1:0] dividend_i,
  input  logic [RegW-1:0] divisor_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [RegW-1:0] quo_o,
  output logic [RegW-1:0] rem_o
);

  div_state_e      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  // work_q[64:32] partial remainder, work_q[31:0] dividend bits shifting out
  // while quotient bits shift in from the bottom.
  logic [64:0]     work_q, work_d;
  logic [RegW-1:0] divisor_q, divisor_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [64:0]     shifted_s;
  logic [32:0]     diff_s;

  // Trial subtraction: bit 32 of diff_s set means the shifted remainder is below the divisor.
  assign shifted_s = {work_q[63:0], 1'b0};
  assign diff_s    = shifted_s[64:32] - {1'b0, divisor_q};

  // Divider next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    busy_o    = 1'b0;
    ready_o   = 1'b0;
    quo_o     = 32'd0;
    rem_o     = 32'd0;
    if (annul_i) begin
      state_d = DivFree;
    end else begin
      case (state_q)
        DivFree: begin
          if (start_i) begin
            busy_o    = 1'b1;
            neg_quo_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
            neg_rem_d = signed_i & dividend_i[31];
            if (divisor_i == 32'd0) begin
              state_d = DivByZero;
            end else begin
              state_d   = DivOn;
              cnt_d     = 6'd0;
              work_d    = {33'd0, cond_neg(dividend_i, signed_i & dividend_i[31])};
              divisor_d = cond_neg(divisor_i, signed_i & divisor_i[31]);
            end
          end else begin
            state_d = DivFree;
          end
        end
        DivByZero: begin
          busy_o  = 1'b1;
          work_d  = 65'd0;
          state_d = DivEnd;
        end
        DivOn: begin
          busy_o = 1'b1;
          if (diff_s[32]) begin
            work_d = shifted_s;
          end else begin
            work_d = {diff_s, shifted_s[31:1], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = DivEnd;
          end else begin
            state_d = DivOn;
          end
        end
        DivEnd: begin
          ready_o = 1'b1;
          quo_o   = cond_neg(work_q[31:0], neg_quo_q);
          rem_o   = cond_neg(work_q[63:32], neg_rem_q);
          state_d = DivFree;
        end
        default: begin
          state_d = DivFree;
        end
      endcase
    end
  end

  // Divider state register; reset clears everything including mid-division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/ex_hilo_unit.sv
// ex_hilo_unit: execute-stage HI/LO unit (MULT*, MADD*/MSUB*, DIV*).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   op                  HI/LO operation code
//   reg1_i, reg2_i      operands (dividend / divisor for DIV*)
//   hi_i, lo_i          forwarded HI/LO (accumulator for MADD*/MSUB*)
//   annul_i             flush of the EX instruction
//   hi_o, lo_o          result to ex_hi / ex_lo
//   whilo_o             result valid this cycle (single pulse per instruction)
//   stallreq_o          hold IF/ID/EX this cycle
module ex_hilo_unit
  import ex_hilo_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [HiLoOpW-1:0] op,
  input  logic [RegW-1:0]    reg1_i,
  input  logic [RegW-1:0]    reg2_i,
  input  logic [RegW-1:0]    hi_i,
  input  logic [RegW-1:0]    lo_i,
  input  logic               annul_i,
  output logic [RegW-1:0]    hi_o,
  output logic [RegW-1:0]    lo_o,
  output logic               whilo_o,
  output logic               stallreq_o
);

  logic            acc_phase_q, acc_phase_d;
  logic [63:0]     prod_q, prod_d;
  logic            mul_signed_s;
  logic [63:0]     opa_s, opb_s, prod_s;
  logic            div_start_s, div_busy_s, div_ready_s;
  logic [RegW-1:0] div_quo_s, div_rem_s;
  logic [RegW-1:0] hi_s, lo_s;
  logic            whilo_s, stall_s;

  // Operands are extended to 64 bits so one multiplier covers signed and unsigned.
  assign mul_signed_s = (op == HiLoMult) || (op == HiLoMadd) || (op == HiLoMsub);
  assign opa_s  = mul_signed_s ? {{32{reg1_i[31]}}, reg1_i} : {32'd0, reg1_i};
  assign opb_s  = mul_signed_s ? {{32{reg2_i[31]}}, reg2_i} : {32'd0, reg2_i};
  assign prod_s = opa_s * opb_s;

  assign div_start_s = (op == HiLoDiv) || (op == HiLoDivu);

  hilo_div u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start_s),
    .annul_i    (annul_i),
    .signed_i   (op == HiLoDiv),
    .dividend_i (reg1_i),
    .divisor_i  (reg2_i),
    .busy_o     (div_busy_s),
    .ready_o    (div_ready_s),
    .quo_o      (div_quo_s),
    .rem_o      (div_rem_s)
  );

  // Result select, accumulate phase sequencing and stall/valid generation.
  always_comb begin
    hi_s        = 32'd0;
    lo_s        = 32'd0;
    whilo_s     = 1'b0;
    stall_s     = 1'b0;
    acc_phase_d = 1'b0;
    prod_d      = prod_q;
    if (annul_i) begin
      acc_phase_d = 1'b0;
    end else begin
      case (op)
        HiLoMult, HiLoMultu: begin
          {hi_s, lo_s} = prod_s;
          whilo_s      = 1'b1;
        end
        HiLoMadd, HiLoMaddu, HiLoMsub, HiLoMsubu: begin
          if (!acc_phase_q) begin
            prod_d      = prod_s;
            acc_phase_d = 1'b1;
            stall_s     = 1'b1;
          end else begin
            if ((op == HiLoMsub) || (op == HiLoMsubu)) begin
              {hi_s, lo_s} = {hi_i, lo_i} - prod_q;
            end else begin
              {hi_s, lo_s} = {hi_i, lo_i} + prod_q;
            end
            whilo_s = 1'b1;
          end
        end
        HiLoDiv, HiLoDivu: begin
          stall_s      = div_busy_s;
          whilo_s      = div_ready_s;
          {hi_s, lo_s} = div_ready_s ? {div_rem_s, div_quo_s} : 64'd0;
        end
        default: begin
          acc_phase_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign hi_o       = rst ? 32'd0 : hi_s;
  assign lo_o       = rst ? 32'd0 : lo_s;
  assign whilo_o    = rst ? 1'b0  : whilo_s;
  assign stallreq_o = rst ? 1'b0  : stall_s;

  // Accumulate phase flag and registered product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_phase_q <= 1'b0;
      prod_q      <= 64'd0;
    end else begin
      acc_phase_q <= acc_phase_d;
      prod_q      <= prod_d;
    end
  end

endmodule

// File: tb/tb_ex_hilo_unit.sv
module tb_ex_hilo_unit;
  import ex_hilo_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
  logic        annul_i;
  logic [31:0] hi_o, lo_o;
  logic        whilo_o, stallreq_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_hilo_unit dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .annul_i    (annul_i),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .whilo_o    (whilo_o),
    .stallreq_o (stallreq_o)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, h, l;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_w, exp_s;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l);
    op = o; reg1_i = a; reg2_i = b; hi_i = h; lo_i = l;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_whilo"}, {63'd0, whilo_o}, 64'd0);
    chk({name, "_stall"}, {63'd0, stallreq_o}, 64'd0);
  endtask

  task automatic run_madd(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                          input logic [63:0] exp);
    step();
    drive(o, a, b, h, l);
    @(negedge clk);
    chk({name, "_p0_stall"}, {63'd0, stallreq_o}, 64'd1);
    chk({name, "_p0_whilo"}, {63'd0, whilo_o}, 64'd0);
    step();
    @(negedge clk);
    chk({name, "_p1_stall"}, {63'd0, stallreq_o}, 64'd0);
    chk({name, "_p1_whilo"}, {63'd0, whilo_o}, 64'd1);
    chk({name, "_hilo"}, {hi_o, lo_o}, exp);
    step();
    op = HiLoNop;
    @(negedge clk);
    chk_idle({name, "_after"});
  endtask

  task automatic run_div(input string name, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_stalls);
    int  stalls;
    logic done;
    stalls = 0;
    done   = 1'b0;
    step();
    drive(o, a, b, 32'h0, 32'h0);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (whilo_o) begin
        done = 1'b1;
        chk({name, "_end_stall"}, {63'd0, stallreq_o}, 64'd0);
        chk({name, "_hilo"}, {hi_o, lo_o}, {exp_hi, exp_lo});
      end else begin
        if (stallreq_o) stalls++;
        step();
      end
    end
    chk({name, "_done"}, {63'd0, done}, 64'd1);
    chk({name, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    step();
    op = HiLoNop;
    @(negedge clk);
    chk_idle({name, "_after"});
  endtask

  initial begin
    vecs[0] = '{HiLoMult,  32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[1] = '{HiLoMultu, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[2] = '{HiLoMult,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h1, 1'b1, 1'b0};
    vecs[3] = '{HiLoMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0};
    vecs[4] = '{HiLoMult,  32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h0, 1'b1, 1'b0};
    vecs[5] = '{HiLoNop,   32'h12345678, 32'h9ABCDEF0, 32'h11, 32'h22, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[6] = '{4'hF,      32'h12345678, 32'h9ABCDEF0, 32'h11, 32'h22, 32'h0, 32'h0, 1'b0, 1'b0};

    rst = 1'b1;
    annul_i = 1'b0;
    drive(HiLoMult, 32'hFFFFFFFF, 32'h2, 32'h5, 32'h6);
    @(negedge clk);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk_idle("rst");
    step();
    rst = 1'b0;
    op  = HiLoNop;
    @(negedge clk);
    chk_idle("rst_release");

    for (int i = 0; i < 7; i++) begin
      step();
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].l);
      @(negedge clk);
      chk($sformatf("vec%0d_hilo", i), {hi_o, lo_o}, {vecs[i].exp_hi, vecs[i].exp_lo});
      chk($sformatf("vec%0d_whilo", i), {63'd0, whilo_o}, {63'd0, vecs[i].exp_w});
      chk($sformatf("vec%0d_stall", i), {63'd0, stallreq_o}, {63'd0, vecs[i].exp_s});
    end

    run_madd("madd",  HiLoMadd,  32'd3, 32'd4, 32'h0, 32'h5, 64'h0000000000000011);
    run_madd("msubu", HiLoMsubu, 32'd1, 32'd1, 32'h0, 32'h0, 64'hFFFFFFFFFFFFFFFF);
    run_madd("msub",  HiLoMsub,  32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, 64'h0000000000000002);
    run_madd("maddu", HiLoMaddu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 64'hFFFFFFFF00000000);

    run_div("div_m7_2",   HiLoDiv,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_div("divu_100_7", HiLoDivu, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_div("div_min_m1", HiLoDiv,  32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
    run_div("div_7_m2",   HiLoDiv,  32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);
    run_div("div_by0",    HiLoDiv,  32'd1234, 32'd0, 32'd0, 32'd0, 2);

    // Annul in the middle of a division (cnt=10).
    step();
    drive(HiLoDivu, 32'd1000, 32'd3, 32'h0, 32'h0);
    for (int c = 0; c < 11; c++) step();
    annul_i = 1'b1;
    @(negedge clk);
    chk_idle("annul");
    step();
    annul_i = 1'b0;
    op = HiLoNop;
    @(negedge clk);
    chk_idle("annul_next");
    run_div("divu_9_3", HiLoDivu, 32'd9, 32'd3, 32'd0, 32'd3, 33);

    // Reset in the middle of a division (cnt=10).
    step();
    drive(HiLoDiv, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0);
    for (int c = 0; c < 11; c++) step();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_hilo", {hi_o, lo_o}, 64'd0);
    chk_idle("rstmid");
    step();
    rst = 1'b0;
    op  = HiLoNop;
    @(negedge clk);
    chk_idle("rstmid_release");
    run_div("post_rst_divu", HiLoDivu, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_hilo_unit.md
# ex_hilo_unit

Multi-cycle HI/LO arithmetic unit inside the execute stage. It computes the 64-bit results of MULT/MULTU, MADD/MADDU, MSUB/MSUBU and DIV/DIVU and drives ex_hi, ex_lo and ex_whilo into the EX/MEM pipeline register. While a multi-cycle operation is in flight it raises a stall request to the pipeline controller. Single-cycle ALU operations bypass it.

## Interface
Parameters:
- none. Widths come from the shared defines: `RegBus` is 31:0 and `HiLoOpBus` is 3:0.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- op  in  `HiLoOpBus`  operation code; `HiLoNop` when the instruction does not write HI/LO
- reg1_i  in  32  operand rs; dividend for DIV/DIVU
- reg2_i  in  32  operand rt; divisor for DIV/DIVU
- hi_i, lo_i  in  32 each  current HI/LO value, already forwarded from MEM/WB
- annul_i  in  1  flush of the EX instruction; aborts any operation in flight
- hi_o, lo_o  out  32 each  result to ex_hi / ex_lo
- whilo_o  out  1  result valid this cycle; feeds ex_whilo
- stallreq_o  out  1  hold IF/ID/EX this cycle

## Operation
- **Upstream contract.** While stallreq_o=1, the upstream stall holds op, reg1_i, reg2_i, hi_i and lo_i stable.
- **MULT/MULTU.** Combinational 64-bit product.
  - MULT treats both operands as signed; MULTU as unsigned.
  - {hi_o, lo_o} = product, whilo_o=1, no stall.
- **MADD/MADDU/MSUB/MSUBU.** Two phases, tracked by a 1-bit register `acc_phase`.
  - Phase 0: product is registered into `prod_q`; stallreq_o=1, whilo_o=0.
  - Phase 1: {hi_o, lo_o} = {hi_i, lo_i} + prod_q for MADD*, or − prod_q for MSUB*, modulo 2^64; whilo_o=1, stallreq_o=0.
  - `acc_phase` clears after phase 1.
- **DIV/DIVU.** Divider state machine with states `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
  - DivFree → DivByZero when op is DIV* and reg2_i==0.
  - DivFree → DivOn when op is DIV* and reg2_i!=0. On entry, load the magnitudes (DIV negates negative operands) and clear the 6-bit counter cnt.
  - DivOn: one restoring-division step per cycle. cnt==31 on the step → DivEnd.
  - DivByZero → DivEnd, with quotient=0 and remainder=0.
  - DivEnd: apply signs for DIV. The quotient is negated if operand signs differ; the remainder takes the dividend's sign. Drive lo_o=quotient, hi_o=remainder, whilo_o=1, stallreq_o=0. Next state is DivFree unconditionally.
  - 0x80000000 / 0xFFFFFFFF (DIV) → lo=0x80000000, hi=0 (wraps, no trap).
  - stallreq_o=1 in DivFree-with-DIV-op, DivByZero and DivOn.
- **Annul.**
  - annul_i=1 forces divider state to DivFree and acc_phase to 0 on the next edge.
  - In the annul cycle itself: whilo_o=0 and stallreq_o=0.
- **Other ops.** `HiLoNop` and unknown codes drive hi_o=lo_o=0, whilo_o=0, stallreq_o=0.
- **Reset.**
  - While rst=1, all outputs are 0.
  - Divider state returns to DivFree; cnt, prod_q and acc_phase clear immediately, including mid-division.

## Timing
- MULT/MULTU: 0-cycle latency, combinational to the EX/MEM flop.
- MADD*/MSUB*: result in the 2nd cycle of the instruction's residency in EX; 1 stall cycle.
- DIV* (nonzero divisor): op seen in DivFree at cycle 0. Steps run in cycles 1..32. DivEnd at cycle 33 with the result. 33 stall cycles; EX/MEM captures the result at the end of cycle 33.
- DIV* by zero: DivByZero at cycle 1, DivEnd at cycle 2; 2 stall cycles.
- whilo_o is a single-cycle pulse per instruction. The result is never presented twice.
- A back-to-back DIV following DivEnd starts from DivFree in the next cycle; there are no dead cycles beyond DivEnd.

## Structure
- Shared defines file (`defs.v`):
  - `HiLoOpBus`
  - op codes `HiLoNop`, `HiLoMult`, `HiLoMultu`, `HiLoMadd`, `HiLoMaddu`, `HiLoMsub`, `HiLoMsubu`, `HiLoDiv`, `HiLoDivu`
  - state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd`
- Sub-module `hilo_div` holds the divider FSM, counter, and the 65-bit partial remainder/quotient register, with start/annul/signed inputs and a ready/result output.
- Multiply and accumulate logic stays in `ex_hilo_unit`.

## Test plan
- Reset: assert rst at DivOn cnt=10 → all outputs 0 at once; after release, op=`HiLoNop` → stallreq_o=0.
- MULT 0xFFFFFFFF×0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFFE, whilo=1, no stall. MULTU on the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- MADD hi_i=0, lo_i=5, operands 3×4 → stall 1 cycle, then lo=0x11, hi=0. MSUBU hi_i=lo_i=0, operands 1×1 → hi=lo=0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 (−7/2) → 33 stall cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV by 0 → 2 stall cycles, then hi=lo=0, whilo=1 for exactly 1 cycle.
- annul_i at DivOn cnt=10 → stallreq_o=0 and whilo_o=0 that cycle; DivFree next cycle; a following DIVU 9/3 completes normally with lo=3, hi=0.
